// File: rtl/mda_motor_control_pwm_decode.sv
// mda_motor_control_pwm_decode: recovers frame length, drive width, direction and duty command from the H-bridge dir/on pair
module mda_motor_control_pwm_decode #(
  parameter int               WIDTH       = 16,
  parameter int               SYNC_STAGES = 2,
  parameter logic [WIDTH-1:0] TIMEOUT     = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             dir_in,
  input  logic             on_in,
  output logic [WIDTH-1:0] meas_period,
  output logic [WIDTH-1:0] meas_high,
  output logic             meas_dir,
  output logic [WIDTH-1:0] duty_est,
  output logic             valid,
  output logic             stalled,
  output logic             level
);
  typedef enum logic [1:0] {IDLE, ARMED, MEASURE} state_t;
  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] on_sync_q, on_sync_d, dir_sync_q, dir_sync_d;
  logic                   hist_q, hist_d, dir_prev_q, dir_prev_d, dir_cap_q, dir_cap_d;
  logic [WIDTH-1:0]       cnt_q, cnt_d, hcnt_q, hcnt_d;
  logic [WIDTH-1:0]       period_q, period_d, high_q, high_d, duty_q, duty_d;
  logic                   mdir_q, mdir_d, valid_q, valid_d, stalled_q, stalled_d;
  logic                   on_s, dir_s, rise, fall, active, timeout, take, stall;
  logic [WIDTH-1:0]       cnt_inc, half, corr_h;

  assign on_s        = on_sync_q[SYNC_STAGES-1];
  assign dir_s       = dir_sync_q[SYNC_STAGES-1];
  assign meas_period = period_q;
  assign meas_high   = high_q;
  assign meas_dir    = mdir_q;
  assign duty_est    = duty_q;
  assign valid       = valid_q;
  assign stalled     = stalled_q;
  assign level       = on_s;

  // synchroniser shift, edge history and one-cycle-delayed dir for capture on the last high cycle
  always_comb begin
    on_sync_d  = {on_sync_q[SYNC_STAGES-2:0], on_in};
    dir_sync_d = {dir_sync_q[SYNC_STAGES-2:0], dir_in};
    hist_d     = on_s;
    dir_prev_d = dir_s;
  end

  // edge and timeout events; timeout fires as cnt steps onto TIMEOUT, so a rise on that cycle still measures
  always_comb begin
    rise    = on_s & ~hist_q;
    fall    = ~on_s & hist_q;
    active  = state_q != IDLE;
    cnt_inc = cnt_q + WIDTH'(1);
    timeout = cnt_inc == TIMEOUT;
    take    = active & rise;
    stall   = active & ~rise & timeout;
    half    = (cnt_q - WIDTH'(1)) >> 1;
    corr_h  = (cnt_q - hcnt_q) >> 1;
  end

  // next state
  always_comb begin
    state_d = !active ? (rise ? ARMED : IDLE) : rise ? MEASURE : timeout ? IDLE : fall ? MEASURE : state_q;
  end

  // frame counters and measurement outputs, duty reconstructed from the frame being closed
  always_comb begin
    cnt_d     = rise ? WIDTH'(1) : active ? cnt_inc : cnt_q;
    hcnt_d    = rise ? WIDTH'(1) : (active & on_s) ? hcnt_q + WIDTH'(1) : hcnt_q;
    dir_cap_d = (active & fall) ? dir_prev_q : dir_cap_q;
    period_d  = take ? cnt_q : stall ? '0 : period_q;
    high_d    = take ? hcnt_q : stall ? '0 : high_q;
    mdir_d    = take ? dir_cap_q : stall ? 1'b0 : mdir_q;
    duty_d    = take ? (dir_cap_q ? half + corr_h : (corr_h > half ? '0 : half - corr_h)) : stall ? '0 : duty_q;
    valid_d   = take | stall;
    stalled_d = take ? 1'b0 : stall ? 1'b1 : stalled_q;
  end

  // state and datapath registers, cleared asynchronously
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      on_sync_q  <= '0;
      dir_sync_q <= '0;
      hist_q     <= 1'b0;
      dir_prev_q <= 1'b0;
      dir_cap_q  <= 1'b0;
      cnt_q      <= '0;
      hcnt_q     <= '0;
      period_q   <= '0;
      high_q     <= '0;
      duty_q     <= '0;
      mdir_q     <= 1'b0;
      valid_q    <= 1'b0;
      stalled_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      on_sync_q  <= on_sync_d;
      dir_sync_q <= dir_sync_d;
      hist_q     <= hist_d;
      dir_prev_q <= dir_prev_d;
      dir_cap_q  <= dir_cap_d;
      cnt_q      <= cnt_d;
      hcnt_q     <= hcnt_d;
      period_q   <= period_d;
      high_q     <= high_d;
      duty_q     <= duty_d;
      mdir_q     <= mdir_d;
      valid_q    <= valid_d;
      stalled_q  <= stalled_d;
    end
  end
endmodule

// File: tb/tb_mda_motor_control_pwm_decode.sv
// tb_mda_motor_control_pwm_decode: directed vectors and corner sequences for the PWM decoder
module tb_mda_motor_control_pwm_decode;
  localparam int           W  = 16;
  localparam logic [W-1:0] TO = 16'd50;
  logic clk = 1'b0, reset_n = 1'b0, dir_in = 1'b0, on_in = 1'b0;
  logic [W-1:0] p0, h0, u0, p1, h1, u1;
  logic d0, v0, s0, l0, d1, v1, s1, l1;
  int n_chk = 0, n_fail = 0, cyc = 0;
  logic pv0 = 1'b0;

  typedef struct {int c; logic [W-1:0] p, h, u; logic d, s, l;} obs_t;
  typedef struct {int per, hi; logic d; logic [W-1:0] ep, eh; logic ed; logic [W-1:0] eu;} vec_t;
  obs_t q0[$], q1[$];
  vec_t vt[8];

  mda_motor_control_pwm_decode #(.WIDTH(W), .SYNC_STAGES(2), .TIMEOUT(TO)) dut0 (
    .clk(clk), .reset_n(reset_n), .dir_in(dir_in), .on_in(on_in),
    .meas_period(p0), .meas_high(h0), .meas_dir(d0), .duty_est(u0),
    .valid(v0), .stalled(s0), .level(l0));

  mda_motor_control_pwm_decode #(.WIDTH(W), .SYNC_STAGES(3), .TIMEOUT(TO)) dut1 (
    .clk(clk), .reset_n(reset_n), .dir_in(dir_in), .on_in(on_in),
    .meas_period(p1), .meas_high(h1), .meas_dir(d1), .duty_est(u1),
    .valid(v1), .stalled(s1), .level(l1));

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (v0) begin
      q0.push_back('{cyc, p0, h0, u0, d0, s0, l0});
      n_chk++;
      if (pv0) begin
        n_fail++;
        $display("FAIL valid_back_to_back: valid high on 2 consecutive cycles at cycle %0d, required isolated pulses", cyc);
      end
    end
    if (v1) q1.push_back('{cyc, p1, h1, u1, d1, s1, l1});
    pv0 = v0;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_obs(input string nm, input obs_t o, input int p, input int h, input int d, input int u, input int s);
    chk({nm, "_period"}, o.p, p);
    chk({nm, "_high"}, o.h, h);
    chk({nm, "_dir"}, o.d, d);
    chk({nm, "_duty"}, o.u, u);
    chk({nm, "_stalled"}, o.s, s);
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_period"}, p0, 0);
    chk({nm, "_high"}, h0, 0);
    chk({nm, "_dir"}, d0, 0);
    chk({nm, "_duty"}, u0, 0);
    chk({nm, "_valid"}, v0, 0);
    chk({nm, "_stalled"}, s0, 0);
    chk({nm, "_level"}, l0, 0);
  endtask

  task automatic frame(input int per, input int hi, input logic d);
    for (int i = 0; i < per; i++) begin
      on_in  = (i < hi);
      dir_in = d;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    int s, lat0, lat1;
    bit found;
    vt[0] = '{10, 4,  1'b1, 16'd10, 16'd4,  1'b1, 16'd7};
    vt[1] = '{10, 4,  1'b0, 16'd10, 16'd4,  1'b0, 16'd1};
    vt[2] = '{16, 8,  1'b1, 16'd16, 16'd8,  1'b1, 16'd11};
    vt[3] = '{6,  2,  1'b0, 16'd6,  16'd2,  1'b0, 16'd0};
    vt[4] = '{12, 11, 1'b1, 16'd12, 16'd11, 1'b1, 16'd5};
    vt[5] = '{2,  1,  1'b1, 16'd2,  16'd1,  1'b1, 16'd0};
    vt[6] = '{4,  1,  1'b0, 16'd4,  16'd1,  1'b0, 16'd0};
    vt[7] = '{7,  3,  1'b1, 16'd7,  16'd3,  1'b1, 16'd5};

    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
    reset_n = 1'b1;
    frame(3, 0, 1'b0);

    for (int k = 0; k < 8; k++) begin
      s = q0.size();
      for (int f = 0; f < 5; f++) frame(vt[k].per, vt[k].hi, vt[k].d);
      chk($sformatf("v%0d_valid_count", k), q0.size() >= s + 2, 1);
      if (q0.size() >= s + 2) begin
        chk_obs($sformatf("v%0d", k), q0[$], vt[k].ep, vt[k].eh, vt[k].ed, vt[k].eu, 0);
        chk($sformatf("v%0d_spacing", k), q0[$].c - q0[$-1].c, vt[k].per);
      end
      chk($sformatf("v%0d_s3_seen", k), q1.size() > 0, 1);
      if (q1.size() > 0) begin
        chk($sformatf("v%0d_s3_period", k), q1[$].p, vt[k].ep);
        chk($sformatf("v%0d_s3_duty", k), q1[$].u, vt[k].eu);
      end
    end

    frame(10, 4, 1'b1);
    frame(10, 4, 1'b1);
    s = q0.size();
    frame(13, 4, 1'b1);
    frame(16, 8, 1'b1);
    chk("chg_count", q0.size() >= s + 2, 1);
    if (q0.size() >= s + 2) chk_obs("chg_mixed", q0[s+1], 13, 4, 1, 10, 0);
    repeat (3) frame(16, 8, 1'b1);
    chk_obs("chg_steady", q0[$], 16, 8, 1, 11, 0);

    lat0 = 0;
    lat1 = 0;
    on_in = 1'b1;
    for (int c = 2; c <= 9; c++) begin
      @(posedge clk); #1;
      if (v0 && lat0 == 0) lat0 = c;
      if (v1 && lat1 == 0) lat1 = c;
    end
    frame(8, 0, 1'b1);
    chk("latency_s2", lat0, 2 + 2);
    chk("latency_s3", lat1, 3 + 2);

    s = q0.size();
    frame(49, 4, 1'b1);
    frame(10, 4, 1'b1);
    chk("edge49_count", q0.size() >= s + 2, 1);
    if (q0.size() >= s + 2) chk_obs("edge49", q0[s+1], 49, 4, 1, 46, 0);

    frame(10, 4, 1'b1);
    s = q0.size();
    on_in = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 120 && !found; i++) begin
      @(posedge clk); #1;
      found = q0.size() > s && q0[$].s;
    end
    chk("stall_seen", found, 1);
    if (found) begin
      chk_obs("stall", q0[$], 0, 0, 0, 0, 1);
      chk("stall_level", q0[$].l, 1);
      chk("stall_spacing", q0[$].c - q0[$-1].c, TO - 1);
    end
    frame(5, 0, 1'b1);
    chk("stuck_low_level", l0, 0);
    s = q0.size();
    frame(10, 4, 1'b1);
    chk("restart_arm_only", q0.size(), s);
    chk("restart_still_stalled", s0, 1);
    frame(10, 4, 1'b1);
    chk("restart_count", q0.size(), s + 1);
    if (q0.size() == s + 1) chk_obs("restart", q0[$], 10, 4, 1, 7, 0);

    on_in = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #3;
    reset_n = 1'b0;
    #1;
    chk_zero("async_reset");
    for (int i = 0; i < 4; i++) begin
      on_in = ~on_in;
      @(posedge clk); #1;
    end
    on_in = 1'b0;
    reset_n = 1'b1;
    frame(4, 0, 1'b0);
    s = q0.size();
    frame(10, 4, 1'b0);
    chk("post_reset_arm_only", q0.size(), s);
    frame(10, 4, 1'b0);
    chk("post_reset_count", q0.size(), s + 1);
    if (q0.size() == s + 1) chk_obs("post_reset", q0[$], 10, 4, 0, 1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/mda_motor_control_pwm_decode.md
# mda_motor_control_pwm_decode

Decoder for the motor H-bridge drive pair (`dir`, `on`) produced by the motor control PWM generator. Synchronises both lines, measures each PWM frame rising-edge-to-rising-edge of `on`, and reconstructs:
- frame length;
- drive-phase width;
- direction;
- the original 16-bit duty command in the generator's centred-at-50% encoding.

Sits in `mda_motor_control` as a loop-back monitor on each motor channel, feeding the Avalon status registers and the stall detector.

## Interface
- `WIDTH`, 16, width of all counters and measurement outputs (matches `PERIOD_LENGTH`).
- `SYNC_STAGES`, 2, flip-flop stages on each input line (≥2).
- `TIMEOUT`, 16'hFFFF, cycles without a detected `on` rise before declaring a stall (≤ 2^WIDTH-1).

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  system clock, all logic on posedge.
- `reset_n`  in  1  asynchronous active-low reset.
- `dir_in`  in  1  H-bridge direction line (asynchronous to `clk`).
- `on_in`  in  1  H-bridge enable line (asynchronous to `clk`).
- `meas_period`  out  WIDTH  cycles between last two detected `on` rises (= generator period+1).
- `meas_high`  out  WIDTH  cycles `on` was high within that frame.
- `meas_dir`  out  1  synchronised `dir` sampled on the last high cycle of the frame.
- `duty_est`  out  WIDTH  reconstructed duty command.
- `valid`  out  1  one-cycle pulse when the measurement outputs update.
- `stalled`  out  1  level; no `on` rise within `TIMEOUT` cycles.
- `level`  out  1  synchronised `on` value (for diagnosing constant-drive vs constant-brake stall).

## Operation
- **Input path:** each input passes through `SYNC_STAGES` flops; then one history flop on synced `on` for edge detection. A rise is synced `on` == 1 with history == 0; a fall is the converse.
- **State machine:** `IDLE`, `ARMED`, `MEASURE`.
  - `IDLE` → `ARMED` on the first rise. `cnt` is set to 1 and `hcnt` to 1, which counts the rise cycle itself.
  - `ARMED`/`MEASURE`: every cycle `cnt`++, and `hcnt`++ while synced `on` is 1. On a fall, `dir_cap` ← synced `dir` from the previous cycle; `ARMED` → `MEASURE`.
  - `MEASURE` on a rise:
    - latch `meas_period` ← `cnt`, `meas_high` ← `hcnt`, `meas_dir` ← `dir_cap`;
    - compute `duty_est`;
    - pulse `valid`; clear `stalled`;
    - set `cnt` = 1, `hcnt` = 1; stay in `MEASURE`.
  - `ARMED` on a rise means there was no fall in the frame, which is impossible with the synced edge definition. Treat it as `MEASURE`.
- **duty_est arithmetic**, all WIDTH-bit unsigned, computed from the latched values:
  - `half` = (`meas_period`−1)>>1;
  - `corr` = `meas_period` − `meas_high`;
  - `duty_est` = `meas_dir` ? `half` + (`corr`>>1) : `half` − (`corr`>>1).
  - If `corr`>>1 > `half` in reverse, `duty_est` saturates to 0.
- **Stall:** when `cnt` reaches `TIMEOUT` in `ARMED`/`MEASURE`:
  - `stalled` ← 1, `valid` pulses once;
  - `meas_period`, `meas_high`, `duty_est` ← 0; `meas_dir` ← 0;
  - state → `IDLE`; `cnt` holds.
  - `level` still shows whether the line is stuck high or stuck low.
- **After a stall or reset**, the first rise only arms. The partial frame is discarded, and the next `valid` comes on the second rise.
- **Simultaneous timeout and rise:** the rise wins; it is a normal measurement and `stalled` is not set.

## Timing
- **Reset values** (while `reset_n` = 0, immediately and asynchronously): all sync flops 0, history 0, state `IDLE`, `cnt` 0, `hcnt` 0. Outputs: `meas_period` 0, `meas_high` 0, `meas_dir` 0, `duty_est` 0, `valid` 0, `stalled` 0, `level` 0.
- **Reset mid-frame:** the frame is discarded; nothing is latched.
- **Latency:**
  - raw `on_in` rise → internal rise detect: `SYNC_STAGES`+1 cycles;
  - `valid` and all measurement outputs are registered and update together on the cycle after detect, so raw edge → `valid` = `SYNC_STAGES`+2 cycles.
  - Outputs hold between `valid` pulses.
- **Minimum resolvable pulse:** a high or low phase must be ≥1 synced cycle; shorter glitches are invisible.
- **Maximum measurable frame:** `TIMEOUT`−1 cycles.
- `valid` is never high two consecutive cycles. The minimum spacing is `meas_period` ≥ 2.

## Test plan
- **Reset:** drive `reset_n` = 0 mid-frame with `on_in` toggling → all outputs 0 within the same cycle; after release, no `valid` until the second rise.
- **Forward:** generator period = 9, duty = 7, on = 1 (frame 10, `on` high 4) → `valid` with `meas_period` = 10, `meas_high` = 4, `meas_dir` = 1, `duty_est` = 7; repeats every 10 cycles.
- **Reverse:** same period, duty = 1 → `meas_period` = 10, `meas_high` = 4, `meas_dir` = 0, `duty_est` = 1.
- **Stall:** hold `on_in` = 1 after one valid frame, `TIMEOUT` = 50 → `valid` pulse with `stalled` = 1, measurements 0, `level` = 1. Restart the generator → `stalled` clears on the second rise with a correct measurement.
- **Period change:** period 9 → 15 mid-run, duty 12 → the first frame after the change reports the mixed partial length; then steady `meas_period` = 16, `meas_high` = 8, `duty_est` = 11. With odd-period floor this is within 1 of the command; the bench compares against the reconstruction formula.
- **Latency:** measure raw `on_in` rise → `valid` = `SYNC_STAGES`+2 cycles, for `SYNC_STAGES` = 2 and 3.
